// File: rtl/lsu_pkg.sv
// Shared definitions for the split-capable load/store unit.
//   - SZ_*        : access size encodings carried on i_size
//   - lsu_state_e : controller FSM states
//   - lane_strb() : byte-strobe pattern for beat 0 or beat 1 of an access
//   - extend()    : sign/zero extension of a right-aligned load value
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } lsu_state_e;

    // The access mask shifted by the byte offset spans up to two bus words.
    // Beat 0 owns the low B bits of that span, beat 1 the next B bits.
    // ob is log2 of the bus width in bytes; callers truncate to B bits.
    function automatic logic [7:0] lane_strb(input logic [2:0] off,
                                             input logic [1:0] size,
                                             input logic       beat,
                                             input logic [1:0] ob);
        logic [15:0] mask;
        logic [15:0] full;
        mask = (16'd1 << (4'd1 << size)) - 16'd1;
        full = mask << off;
        if (beat) begin
            full = full >> (4'd1 << ob);
        end
        return full[7:0];
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] raw,
                                           input logic [1:0]  size,
                                           input logic        is_unsigned);
        logic [63:0] r;
        r = raw;
        case (size)
            SZ_B:    r = is_unsigned ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            SZ_H:    r = is_unsigned ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            SZ_W:    r = is_unsigned ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane alignment for the load/store unit.
// Ports:
//   off        in  byte offset of the access inside a bus word
//   size       in  access size (SZ_*)
//   beat       in  0 = first beat, 1 = second beat of a split access
//   wdata      in  right-aligned store data
//   is_unsigned in 1 = zero-extend load data
//   rdata0/1   in  raw read data of beat 0 / beat 1 (beat 1 = 0 when unused)
//   strb       out byte strobes of the selected beat
//   wdata_lane out store data positioned on the bus lanes of the selected beat
//   split      out access crosses a bus-word boundary
//   rdata_ext  out merged, right-aligned and extended load data
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int B      = DATA_W / 8,
    localparam int OB     = $clog2(B)
) (
    input  logic [OB-1:0]     off,
    input  logic [1:0]        size,
    input  logic              beat,
    input  logic [DATA_W-1:0] wdata,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] rdata0,
    input  logic [DATA_W-1:0] rdata1,
    output logic [B-1:0]      strb,
    output logic [DATA_W-1:0] wdata_lane,
    output logic              split,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [OB+2:0]       sh0;
    logic [OB+3:0]       sh1;
    logic [4:0]          span;
    logic [2*DATA_W-1:0] cat;

    // sh0 moves data up to its lane in beat 0; sh1 pulls the bytes that
    // spilled past the top lane down to the bottom of beat 1.
    assign sh0  = {off, 3'b000};
    assign sh1  = (OB+4)'(DATA_W) - {1'b0, sh0};
    assign span = 5'(off) + (5'd1 << size);

    assign split      = span > 5'(B);
    assign strb       = B'(lane_strb(3'(off), size, beat, 2'(OB)));
    assign wdata_lane = beat ? (wdata >> sh1) : (wdata << sh0);

    assign cat       = {rdata1, rdata0} >> sh0;
    assign rdata_ext = DATA_W'(extend(64'(cat[DATA_W-1:0]), size, is_unsigned));

endmodule

// File: rtl/lsu_split_ctrl.sv
// Sequential load/store unit between the EXU and a valid/ready memory port.
// Accepts one access at a time, issues one or two bus-aligned beats (two when
// the access crosses a bus word), merges read beats and extends load data.
// Ports:
//   clock, reset                    clock, synchronous active-high reset
//   i_req_valid/o_req_ready         request handshake (ready only in IDLE)
//   i_wen,i_addr,i_wdata,i_size,i_unsigned  request fields
//   o_resp_valid/i_resp_ready       response handshake
//   o_rdata,o_fault                 response payload
//   o_mem_valid/i_mem_ready         beat request handshake
//   o_mem_addr,o_mem_wen,o_mem_wdata,o_mem_wstrb  beat fields
//   i_mem_rvalid,i_mem_rdata,i_mem_err            beat response
module lsu_split_ctrl
    import lsu_pkg::*;
#(
    parameter  int ADDR_W         = 32,
    parameter  int DATA_W         = 32,
    parameter  bit ALLOW_MISALIGN = 1'b1,
    localparam int B              = DATA_W / 8,
    localparam int OB             = $clog2(B)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_fault,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wen,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [B-1:0]      o_mem_wstrb,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_err
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              wen_q, wen_d;
    logic              uns_q, uns_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fault_q, fault_d;

    logic              beat_sel;
    logic [DATA_W-1:0] al_rd0, al_rd1;
    logic [B-1:0]      al_strb;
    logic [DATA_W-1:0] al_wdata;
    logic              al_split;
    logic [DATA_W-1:0] al_rdata;
    logic [ADDR_W-1:0] base_addr;

    logic [7:0]        in_off8;
    logic [7:0]        in_nmask;
    logic              in_fault;

    // Faults are decided from the live request so a rejected access never
    // touches the bus.
    assign in_off8  = 8'(i_addr[OB-1:0]);
    assign in_nmask = (8'd1 << i_size) - 8'd1;
    assign in_fault = (i_size > 2'(OB)) ||
                      (!ALLOW_MISALIGN && ((in_off8 & in_nmask) != 8'd0));

    assign beat_sel  = (state_q == ST_REQ1) || (state_q == ST_WAIT1);
    assign base_addr = {addr_q[ADDR_W-1:OB], OB'(0)};

    // Beat 0 data is live in WAIT0 and parked in rdata0_q for the merge in
    // WAIT1; beat 1 only exists while WAIT1 is receiving it.
    assign al_rd0 = (state_q == ST_WAIT0) ? i_mem_rdata : rdata0_q;
    assign al_rd1 = (state_q == ST_WAIT1) ? i_mem_rdata : '0;

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .off        (addr_q[OB-1:0]),
        .size       (size_q),
        .beat       (beat_sel),
        .wdata      (wdata_q),
        .is_unsigned(uns_q),
        .rdata0     (al_rd0),
        .rdata1     (al_rd1),
        .strb       (al_strb),
        .wdata_lane (al_wdata),
        .split      (al_split),
        .rdata_ext  (al_rdata)
    );

    assign o_mem_addr   = beat_sel ? (base_addr + ADDR_W'(B)) : base_addr;
    assign o_mem_wen    = wen_q;
    assign o_mem_wdata  = al_wdata;
    assign o_mem_wstrb  = wen_q ? al_strb : '0;
    assign o_rdata      = rdata_q;
    assign o_fault      = fault_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        wen_d        = wen_q;
        uns_d        = uns_q;
        rdata0_d     = rdata0_q;
        rdata_d      = rdata_q;
        fault_d      = fault_q;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        o_mem_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    addr_d   = i_addr;
                    wdata_d  = i_wdata;
                    size_d   = i_size;
                    wen_d    = i_wen;
                    uns_d    = i_unsigned;
                    rdata0_d = '0;
                    rdata_d  = '0;
                    fault_d  = in_fault;
                    state_d  = in_fault ? ST_RESP : ST_REQ0;
                end
            end
            ST_REQ0: begin
                o_mem_valid = 1'b1;
                if (i_mem_ready) state_d = ST_WAIT0;
            end
            ST_WAIT0: begin
                if (i_mem_rvalid) begin
                    if (i_mem_err) begin
                        fault_d = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else if (al_split) begin
                        rdata0_d = i_mem_rdata;
                        state_d  = ST_REQ1;
                    end else begin
                        rdata_d = wen_q ? '0 : al_rdata;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_REQ1: begin
                o_mem_valid = 1'b1;
                if (i_mem_ready) state_d = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (i_mem_rvalid) begin
                    fault_d = i_mem_err;
                    rdata_d = (wen_q || i_mem_err) ? '0 : al_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                o_resp_valid = 1'b1;
                if (i_resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= SZ_B;
            wen_q    <= 1'b0;
            uns_q    <= 1'b0;
            rdata0_q <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            wen_q    <= wen_d;
            uns_q    <= uns_d;
            rdata0_q <= rdata0_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

endmodule

// File: doc/lsu_split_ctrl.md
Name: lsu_split_ctrl

Overview:
- Sequential, parametrised load/store unit between the EXU and a simple valid/ready memory port.
- Takes one load or store at a time and issues bus-aligned beats.
- Splits any access that crosses a bus-word boundary into two beats, merges read beats, and sign- or zero-extends load data.
- Successor to the combinational DPI-backed LSU. Adds handshakes, bus-width generality, a misalign-trap mode and error reporting.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, bus and register data width in bits. Legal values 32 or 64. B = DATA_W/8 bytes; OB = log2(B).
- ALLOW_MISALIGN, 1. 1 = split boundary-crossing accesses into two beats. 0 = any access with addr not a multiple of the size faults with no bus traffic.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  EXU request valid
- o_req_ready  out  1  LSU accepts a request; high only in IDLE
- i_wen  in  1  1 = store, 0 = load
- i_addr  in  ADDR_W  byte address
- i_wdata  in  DATA_W  store data, right-aligned
- i_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword
- i_unsigned  in  1  1 = zero-extend load data
- o_resp_valid  out  1  response valid
- i_resp_ready  in  1  EXU accepts the response
- o_rdata  out  DATA_W  extended load data; 0 for stores and faults
- o_fault  out  1  access fault or bus error
- o_mem_valid  out  1  beat request valid
- i_mem_ready  in  1  memory accepts the beat
- o_mem_addr  out  ADDR_W  beat address, B-aligned
- o_mem_wen  out  1  beat is a write
- o_mem_wdata  out  DATA_W  beat write data, lane-positioned
- o_mem_wstrb  out  B  beat byte strobes; 0 for reads
- i_mem_rvalid  in  1  beat response valid
- i_mem_rdata  in  DATA_W  beat read data
- i_mem_err  in  1  beat error, qualified by i_mem_rvalid

Behaviour:
- Reset: state = IDLE, o_req_ready = 1, o_resp_valid = 0, o_mem_valid = 0, o_fault = 0, o_rdata = 0, internal merge registers = 0.
- Request capture: on i_req_valid && o_req_ready, register all request fields. Later i_* changes have no effect.
- Derived values:
  - off = addr[OB-1:0]; n = 1 << size.
  - If size > OB: fault.
  - split = (off + n > B).
  - mask = (1 << n) - 1.
- Beat 0:
  - addr = addr with low OB bits cleared.
  - wstrb = (mask << off) truncated to B bits.
  - wdata = wdata << 8*off.
- Beat 1 (split only):
  - addr = beat0 addr + B, wrapping modulo 2^ADDR_W.
  - wstrb = mask >> (B - off).
  - wdata = wdata >> 8*(B - off).
- Reads: wstrb = 0. Merged raw value = {beat1_rdata, beat0_rdata} >> 8*off. Take the low n bytes, then sign-extend from bit 8n-1, or zero-extend if i_unsigned.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE: on accept, go to REQ0. If the access faults by size or misalign policy, go directly to RESP with fault = 1.
  - REQx: drive o_mem_valid with beat x fields, held stable until i_mem_ready. On handshake, go to WAITx.
  - WAIT0: on i_mem_rvalid, if i_mem_err go to RESP with fault = 1. Else if split go to REQ1. Else go to RESP.
  - WAIT1: on i_mem_rvalid, go to RESP. Fault = i_mem_err.
  - RESP: o_resp_valid = 1. o_rdata and o_fault are held stable until i_resp_ready, then go to IDLE.
- Latency: memory has ready = 1 and rvalid one cycle after the beat handshake; the accept cycle is cycle 0.
  - Non-split access: o_resp_valid rises in cycle 3.
  - Split access: o_resp_valid rises in cycle 5.
- Responses are never dropped and there are no back-to-back accepts. The next request can be accepted in the cycle after the response handshake.
- Only one beat is outstanding at a time. i_mem_rvalid outside WAIT0/WAIT1 is ignored.
- A fault or error forces o_rdata = 0. A beat-0 error suppresses beat 1. A store whose beat-1 write errors leaves beat 0 committed; this is reported only via o_fault.
- Reset in any state returns to IDLE on the next edge and drops o_mem_valid and o_resp_valid. A late i_mem_rvalid after reset is ignored.

Decomposition:
- Shared package lsu_pkg:
  - size encodings (SZ_B/H/W/D)
  - FSM state enum
  - function lane_strb(off, size, beat)
  - function extend(raw, size, unsigned)
- One sub-module, lsu_lane_align: combinational shift/strobe generation and read merge/extend. It is parametrised by DATA_W and instantiated once. The FSM and registers live in lsu_split_ctrl.

Test Plan:
- Aligned lw at 0x8000_0000, mem returns 0xDEADBEEF -> one beat at 0x8000_0000 with wstrb 0000; o_rdata = 0xDEADBEEF; o_resp_valid in cycle 3.
- Split lh signed at 0x8000_0003, beat0 (0x8000_0000) returns 0x11223344, beat1 (0x8000_0004) returns 0x000000AB -> two beats; o_rdata = 0xFFFFAB11; o_resp_valid in cycle 5. Repeat with i_unsigned = 1 -> o_rdata = 0x0000AB11.
- Split sw 0x12345678 at 0x8000_0002 -> beat0: addr 0x8000_0000, wstrb 1100, wdata[31:16] = 0x5678. Beat1: addr 0x8000_0004, wstrb 0011, wdata[15:0] = 0x1234.
- Split lw at 0x8000_0001 with i_mem_err on beat0 -> no beat 1 issued; o_fault = 1; o_rdata = 0. Same access with ALLOW_MISALIGN = 0 -> zero bus beats; fault response in cycle 1.
- i_mem_ready low for 3 cycles during REQ0 -> o_mem_addr, wdata and wstrb stable throughout. i_resp_ready low for 4 cycles -> o_rdata and o_fault stable.
- Reset asserted in WAIT1, then stray i_mem_rvalid -> IDLE, o_resp_valid = 0, o_req_ready = 1; stray response ignored. Next lbu at 0x8000_0007, returning 0x80000000 in beat0 -> o_rdata = 0x00000080.
